// File: rtl/seq_divider.sv
// Sequential restoring divider: 8 shift-subtract iterations per operation, with a divide-by-zero bypass.
// Port vectors are declared [0:WIDTH-1] with index 0 as the LSB; internally values are held as [WIDTH-1:0].
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [0:WIDTH-1] A,
   input  logic [0:WIDTH-1] B,
   output logic [0:WIDTH-1] Q,
   output logic [0:WIDTH-1] R,
   output logic             busy,
   output logic             done,
   output logic             dz
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           r_state, w_next;
   logic [WIDTH-1:0] w_a, w_b;
   logic [WIDTH-1:0] r_div, r_b, r_q, r_r;
   logic [WIDTH:0]   r_rem, w_rem_n;
   logic [WIDTH+1:0] w_shift, w_diff;
   logic [WIDTH-1:0] w_div_n;
   logic [CW-1:0]    r_cnt;
   logic             r_dz, w_fits, w_accept;

   // Bit i of each port vector carries weight 2**i.
   always_comb begin
      w_a = '0;
      w_b = '0;
      Q   = '0;
      R   = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         w_a[i] = A[i];
         w_b[i] = B[i];
         Q[i]   = r_q[i];
         R[i]   = r_r[i];
      end
   end

   assign busy     = (r_state == RUN);
   assign done     = (r_state == FIN);
   assign dz       = r_dz;
   assign w_accept = start && (r_state != RUN);

   // One restoring step: shift {rem, dividend} left, trial-subtract B, keep the result if non-negative.
   always_comb begin
      w_shift = {r_rem, r_div[WIDTH-1]};
      w_diff  = w_shift - {2'b00, r_b};
      w_fits  = ~w_diff[WIDTH+1];
      w_rem_n = w_fits ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
      w_div_n = {r_div[WIDTH-2:0], w_fits};
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, FIN: begin
            if (start) w_next = (w_b != '0) ? RUN : FIN;
            else       w_next = IDLE;
         end
         RUN:     if (r_cnt == CW'(WIDTH - 1)) w_next = FIN;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div <= '0;
         r_b   <= '0;
         r_rem <= '0;
         r_cnt <= '0;
         r_q   <= '0;
         r_r   <= '0;
         r_dz  <= 1'b0;
      end else if (w_accept) begin
         r_div <= w_a;
         r_b   <= w_b;
         r_rem <= '0;
         r_cnt <= '0;
         if (w_b == '0) begin
            r_q  <= '1;
            r_r  <= w_a;
            r_dz <= 1'b1;
         end
      end else if (r_state == RUN) begin
         r_div <= w_div_n;
         r_rem <= w_rem_n;
         r_cnt <= r_cnt + CW'(1);
         // Outputs are only updated on the final iteration so partial results never show.
         if (r_cnt == CW'(WIDTH - 1)) begin
            r_q  <= w_div_n;
            r_r  <= w_rem_n[WIDTH-1:0];
            r_dz <= 1'b0;
         end
      end
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 8, meaning operand and result width; the only supported value is 8.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have the port start, input, 1 bit: request to begin a division; sampled only when idle.
REQ-005 The block SHALL have the port A, input, [0:7]: unsigned dividend; index 0 is the LSB.
REQ-006 The block SHALL have the port B, input, [0:7]: unsigned divisor; index 0 is the LSB.
REQ-007 The block SHALL have the port Q, output, [0:7]: quotient; index 0 is the LSB.
REQ-008 The block SHALL have the port R, output, [0:7]: remainder; index 0 is the LSB.
REQ-009 The block SHALL have the port busy, output, 1 bit: high while a division is in progress.
REQ-010 The block SHALL have the port done, output, 1 bit: one-cycle pulse when Q, R and dz become valid.
REQ-011 The block SHALL have the port dz, output, 1 bit: divide-by-zero flag for the last completed operation.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and FIN.
- IDLE -> RUN on start=1 with B!=0.
- IDLE -> FIN on start=1 with B=0.
- RUN -> FIN after 8 iterations.
- FIN -> IDLE unconditionally, unless start=1, which is handled exactly as in IDLE.
REQ-013 On an accepted start edge E0, the block SHALL latch A and B and clear its internal remainder (9 bits) and iteration counter (3 bits).
REQ-014 While in RUN, the block SHALL perform exactly one restoring shift-subtract iteration per rising edge, quotient MSB first:
- Shift {remainder, dividend} left by one.
- Compute remainder minus {0,B} as a 9-bit result.
- If that result is non-negative, commit it and set the quotient bit to 1; otherwise keep the remainder and set the quotient bit to 0.
REQ-015 Normal latency: iterations SHALL occur on edges E1..E8; after E8 done=1 and busy=0 for exactly one cycle, and Q and R hold the results.
REQ-016 Divide by zero: after E0, done=1 and dz=1, with Q=8'hFF and R=A (latched value); no iterations occur.
REQ-017 busy SHALL be 1 exactly in RUN; it SHALL be 1 in the cycle following E0 and 0 in the FIN cycle.
REQ-018 Q, R and dz SHALL change only on the edge that enters FIN and hold their values until the next completion; intermediate values SHALL never appear on Q or R.
REQ-019 dz SHALL be 0 for every completion with B!=0.
REQ-020 start SHALL be ignored while busy=1; operand changes on A and B while busy=1 SHALL NOT affect the result.
REQ-021 A start asserted in the FIN cycle (done=1) SHALL be accepted, giving back-to-back operation with no idle cycle.
REQ-022 Results SHALL satisfy A = Q*B + R with R < B for all B!=0, including A=0 (Q=0, R=0) and A<B (Q=0, R=A).
REQ-023 The block SHALL have no combinational path from any input to any output.

Reset
REQ-024 rst=1 at a rising edge SHALL force state IDLE and Q=0, R=0, busy=0, done=0, dz=0, and clear all internal registers.
REQ-025 rst SHALL take priority over start and over any in-progress iteration; an aborted division SHALL produce no done pulse.
REQ-026 After rst is released, the block SHALL accept start on the first edge at which rst=0.

Verification
REQ-027 A=100, B=7, start pulse at E0 -> busy=1 for 8 cycles; after E8 done=1, Q=14, R=2, dz=0.
REQ-028 A=255, B=1 -> Q=255, R=0; then A=5, B=9 -> Q=0, R=5; then A=0, B=3 -> Q=0, R=0.
REQ-029 A=77, B=0 -> after E0 done=1, dz=1, Q=255, R=77, busy never asserted.
REQ-030 Mid-run, start=1 with A=1, B=1 at E3 -> ignored; completion gives Q=14, R=2 for the original 100/7.
REQ-031 start held high across the done cycle with A=200, B=10 -> second operation accepted on the done edge; 9 edges later Q=20, R=0.
REQ-032 rst=1 at E4 of a run -> all outputs 0 next cycle, no done pulse; a fresh start of 9/2 then gives Q=4, R=1.
